// File: rtl/banked_mem.sv
// Four-bank interleaved word memory with per-bank occupancy counters and a fixed-latency read
// pipeline. Requests to a busy bank stall; malformed requests raise err and are dropped.
module banked_mem #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned BANK_CYCLES = 4,
  parameter int unsigned RD_LAT      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [15:0]       i_data_in,
  input  logic              i_rd,
  input  logic              i_wr,
  output logic [15:0]       o_data_out,
  output logic              o_rd_valid,
  output logic              o_stall,
  output logic [3:0]        o_busy,
  output logic              o_err
);

  localparam int unsigned IdxW      = ADDR_W - 3;
  localparam int unsigned BankWords = 1 << IdxW;
  localparam int unsigned CntW      = $clog2(BANK_CYCLES + 1);

  logic              w_req;
  logic              w_err;
  logic              w_accept;
  logic [1:0]        w_bank;
  logic [IdxW-1:0]   w_idx;
  logic [CntW-1:0]   w_cnt_d [4];

  logic [15:0]       r_mem       [4][BankWords];
  logic [CntW-1:0]   r_cnt       [4];
  logic [3:0]        r_busy;
  logic              r_pipe_vld  [RD_LAT];
  logic [15:0]       r_pipe_data [RD_LAT];

  assign w_bank = i_addr[2:1];
  assign w_idx  = i_addr[ADDR_W-1:3];
  assign w_req  = i_rd | i_wr;
  assign w_err  = (i_rd & i_wr) | (w_req & i_addr[0]);

  // Nothing is accepted while reset is held, so the array cannot be disturbed by it.
  assign w_accept = w_req & ~w_err & ~r_busy[w_bank] & ~rst;

  assign o_stall = w_req & ~w_err & r_busy[w_bank];
  assign o_err   = w_err;
  assign o_busy  = r_busy;

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      w_cnt_d[b] = r_cnt[b];
      if (w_accept && (w_bank == 2'(b))) begin
        w_cnt_d[b] = CntW'(BANK_CYCLES);
      end else if (r_cnt[b] != '0) begin
        w_cnt_d[b] = r_cnt[b] - CntW'(1);
      end
    end
  end

  // busy is registered from the next counter value so it reads counter != 0 without a comparator
  // on the output path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        r_cnt[b] <= '0;
      end
      r_busy <= 4'b0000;
    end else begin
      for (int b = 0; b < 4; b++) begin
        r_cnt[b]  <= w_cnt_d[b];
        r_busy[b] <= (w_cnt_d[b] != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && i_wr) begin
      r_mem[w_bank][w_idx] <= i_data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        r_pipe_vld[i]  <= 1'b0;
        r_pipe_data[i] <= '0;
      end
    end else begin
      r_pipe_vld[0]  <= w_accept & i_rd;
      r_pipe_data[0] <= r_mem[w_bank][w_idx];
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_data[i] <= r_pipe_data[i-1];
      end
    end
  end

  assign o_rd_valid = r_pipe_vld[RD_LAT-1];
  assign o_data_out = r_pipe_vld[RD_LAT-1] ? r_pipe_data[RD_LAT-1] : 16'h0000;

endmodule

// File: doc/banked_mem.md
Name: banked_mem

Overview:
- Four-bank interleaved main-memory model that sits directly downstream of the cache controller and serves its mem_rd / mem_wr requests.
- Reports per-bank busy status so the controller can sequence multi-word fills and evictions without bank conflicts.
- Fixed read latency and bank occupancy; flags malformed requests; rejects conflicting requests with stall.

Parameters:
- ADDR_W, 16, byte-address width; each word is 16 bits, word-aligned.
- BANK_CYCLES, 4, cycles a bank stays busy after accepting a request; must be >= RD_LAT.
- RD_LAT, 2, cycles from read acceptance to data_out valid; must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- addr  in  ADDR_W  byte address; addr[0] must be 0
- data_in  in  16  write data
- rd  in  1  read request
- wr  in  1  write request
- data_out  out  16  read data; valid only in the cycle rd_valid=1, otherwise 0
- rd_valid  out  1  read data valid strobe
- stall  out  1  request not accepted this cycle (combinational)
- busy  out  4  per-bank busy flags (registered)
- err  out  1  malformed request (combinational)

Behaviour:
- Reset: all bank counters=0, busy=4'b0, read pipeline cleared, rd_valid=0, data_out=0. Array contents are not reset.
- Bank select = addr[2:1]. Index within bank = addr[ADDR_W-1:3]. Each bank holds 2^(ADDR_W-3) words.
- Request present when rd|wr.
  - err=1 if (rd&wr) or (request & addr[0]). The request is ignored, stall=0, and no state changes.
  - If not err and busy[bank]=1: stall=1 and the request is ignored. The requester holds its inputs and retries.
  - Otherwise the request is accepted at the clock edge ending cycle n.
- Accepted write: the array word is updated at that edge.
- Accepted read: the array word is captured at that edge into a RD_LAT-deep valid/data pipeline. data_out = word and rd_valid=1 in cycle n+RD_LAT, for exactly one cycle.
- Busy counter per bank:
  - Loaded with BANK_CYCLES on acceptance and decremented each cycle while nonzero.
  - busy[b] = (counter_b != 0), so bank b is busy in cycles n+1 .. n+BANK_CYCLES.
  - Acceptance is possible again in cycle n+BANK_CYCLES+1.
- Accesses to different banks in consecutive cycles are all accepted. Reads in flight complete in issue order. Consecutive accepted reads give rd_valid in consecutive cycles.
- Same-bank read-after-write cannot overlap, because BANK_CYCLES >= RD_LAT. The read returns the written data.
- rst asserted mid-operation:
  - Pending read data is dropped; rd_valid stays 0 afterwards.
  - Counters clear immediately; busy=0 asynchronously.
  - Writes already accepted remain in the array.
- No request: stall=0, err=0, counters keep decrementing.

Test Plan:
- Write 0xBEEF to addr 0x0010 (bank 0), then read 0x0010 once busy[0]=0 -> busy[0]=1 for 4 cycles after each acceptance; rd_valid=1 with data_out=0xBEEF exactly 2 cycles after read acceptance.
- Reads to 0x0000, 0x0002, 0x0004, 0x0006 in 4 consecutive cycles -> no stall; busy ramps to 4'b1111; four rd_valid pulses in consecutive cycles returning the previously written words in order.
- Write 0x0008 then immediately read 0x0008 (same bank 0) -> stall=1 for cycles n+1..n+4; read accepted in cycle n+5; returns the written data.
- rd=wr=1 at 0x0020, and separately rd at odd addr 0x0021 -> err=1, stall=0, busy unchanged, no rd_valid.
- Read accepted, then rst pulsed in the next cycle -> busy=0 immediately; no rd_valid after reset; a later read of a previously written word still returns its value.
- Counter wrap: hold a request to a busy bank for BANK_CYCLES cycles -> accepted exactly in cycle n+BANK_CYCLES+1; no double acceptance.
